// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// -----------------------------------------------------------------------------
// Clocked data-memory responder for the memory stage of a pipelined Y86-64
// core. It serves one load or store at a time over a valid/ready request
// channel and returns the result over a valid/ready response channel.
// Responses appear a fixed, parameterised number of cycles after acceptance.
// Out-of-range addresses are reported on rsp_err, which feeds the ADR status.
//
// Parameters
//   DEPTH    number of DATA_W-bit words (power of two); word index 0..DEPTH-1
//   DATA_W   data width in bits
//   LATENCY  cycles from the accepting edge to the edge that raises rsp_valid (>=1)
//
// Ports
//   clk        in   1       single clock, all state changes on posedge
//   rst        in   1       synchronous active-high reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder accepts a request this cycle
//   req_write  in   1       1 = store, 0 = load
//   req_addr   in   64      word index
//   req_wdata  in   DATA_W  store data
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       memory stage consumes the response
//   rsp_rdata  out  DATA_W  load data; 0 for stores and for errors
//   rsp_err    out  1       address out of range
//   busy       out  1       a transaction is in flight
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 2048,
    parameter int DATA_W  = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter holds LATENCY-1 down to 0; one bit is enough when LATENCY==1.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_write;
    logic [63:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_exec;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic                w_mem_we;

    // Handshake, execute-edge and address decode for the captured request.
    always_comb begin
        w_accept   = (r_state == ST_IDLE) && req_valid && r_req_ready;
        // The access fires on the edge where the countdown has reached zero,
        // so the response rises exactly LATENCY edges after acceptance.
        w_exec     = (r_state == ST_ACCESS) && (r_cnt == {CNT_W{1'b0}});
        w_in_range = (r_addr < 64'(DEPTH));
        // Array index taken only after the full 64-bit range check, so
        // out-of-range addresses can never alias onto low words.
        w_idx      = r_addr[IDX_W-1:0];
        // A reset on the execute edge aborts the store.
        w_mem_we   = w_exec && r_write && w_in_range && !rst;
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_write     <= 1'b0;
            r_addr      <= 64'd0;
            r_wdata     <= {DATA_W{1'b0}};
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_cnt       <= CNT_W'(LATENCY - 1);
                        r_state     <= ST_ACCESS;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (w_exec) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        if (w_in_range) begin
                            r_rsp_err <= 1'b0;
                            if (r_write) begin
                                r_rsp_rdata <= {DATA_W{1'b0}};
                            end else begin
                                r_rsp_rdata <= r_mem[w_idx];
                            end
                        end else begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= {DATA_W{1'b0}};
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    // Response is held until the consumer takes it.
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= {DATA_W{1'b0}};
                        r_rsp_err   <= 1'b0;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= {CNT_W{1'b0}};
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= {DATA_W{1'b0}};
                    r_rsp_err   <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Three responders (LATENCY 2, 1, 4) share the stimulus; `sel` routes the
// handshake to one of them and muxes its outputs back. A per-instance word
// array holds the expected memory contents.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int NI = 3;
    localparam int LATS [NI] = '{2, 1, 4};

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_ready;
    int          sel;

    logic        rr [NI];
    logic        rv [NI];
    logic        re [NI];
    logic        bz [NI];
    logic [63:0] rd [NI];

    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic        busy;
    logic [63:0] rsp_rdata;

    logic [63:0] mdl   [NI][2048];
    bit          known [NI][2048];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dmem_responder #(
            .DEPTH   (2048),
            .DATA_W  (64),
            .LATENCY (LATS[g])
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid && (sel == g)),
            .req_ready (rr[g]),
            .req_write (req_write),
            .req_addr  (req_addr),
            .req_wdata (req_wdata),
            .rsp_valid (rv[g]),
            .rsp_ready (rsp_ready && (sel == g)),
            .rsp_rdata (rd[g]),
            .rsp_err   (re[g]),
            .busy      (bz[g])
        );
    end

    assign req_ready = rr[sel];
    assign rsp_valid = rv[sel];
    assign rsp_err   = re[sel];
    assign busy      = bz[sel];
    assign rsp_rdata = rd[sel];

    initial begin
        #3000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (inst %0d): observed %h expected %h", tag, sel, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!req_ready && k < 20) begin
            tick();
            k++;
        end
        chk("req_ready_wait", 64'(req_ready), 64'd1);
    endtask

    // One full transaction with latency, data and hold checks.
    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wd,
                          input bit scramble, input int hold);
        int          k;
        logic [63:0] exp_d;
        bit          exp_e;
        bit          chk_d;
        logic [63:0] held_d;
        logic [10:0] ix;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        chk("busy_after_accept", 64'(busy), 64'd1);
        ix = addr[10:0];
        if (addr < 64'd2048) begin
            exp_e = 1'b0;
            if (wr) begin
                exp_d = 64'd0;
                chk_d = 1'b1;
                mdl[sel][ix]   = wd;
                known[sel][ix] = 1'b1;
            end else begin
                exp_d = mdl[sel][ix];
                chk_d = known[sel][ix];
            end
        end else begin
            exp_e = 1'b1;
            exp_d = 64'd0;
            chk_d = 1'b1;
        end
        k = 0;
        while (!rsp_valid && k < 50) begin
            if (scramble) begin
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
                req_write = 1'($urandom_range(0, 1));
                rsp_ready = 1'($urandom_range(0, 1));
            end
            tick();
            k++;
        end
        rsp_ready = 1'b0;
        chk("latency", 64'(k), 64'(LATS[sel]));
        chk("rsp_err", 64'(rsp_err), 64'(exp_e));
        if (chk_d) chk("rsp_rdata", rsp_rdata, exp_d);
        chk("req_ready_in_resp", 64'(req_ready), 64'd0);
        held_d = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, held_d);
            chk("hold_err", 64'(rsp_err), 64'(exp_e));
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("post_hs_valid", 64'(rsp_valid), 64'd0);
        chk("post_hs_rdata", rsp_rdata, 64'd0);
        chk("post_hs_err", 64'(rsp_err), 64'd0);
        chk("post_hs_busy", 64'(busy), 64'd0);
        chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rdata"}, rsp_rdata, 64'd0);
        chk({tag, "_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        bit          w;
        int          k;

        for (int i = 0; i < NI; i++)
            for (int j = 0; j < 2048; j++) known[i][j] = 1'b0;

        sel = 0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            sel = i;
            #0;
            chk_reset_outputs("reset");
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < NI; i++) begin
            sel = i;
            #0;
            chk("ready_after_reset", 64'(req_ready), 64'd1);
        end
        sel = 0;
        #0;

        // Store then load back.
        do_req(1'b1, 64'd5, 64'hDEAD_BEEF, 1'b0, 0);
        do_req(1'b0, 64'd5, 64'd0, 1'b0, 0);

        // Top word, first out-of-range word, no alias onto word 0.
        do_req(1'b1, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
        do_req(1'b1, 64'd2047, 64'd1, 1'b0, 0);
        do_req(1'b0, 64'd2047, 64'd0, 1'b0, 0);
        do_req(1'b1, 64'd2048, 64'hBAD0_BAD0, 1'b0, 0);
        do_req(1'b0, 64'd0, 64'd0, 1'b0, 0);

        // All-ones address.
        do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 0);

        // Response held while the consumer stalls.
        do_req(1'b0, 64'd5, 64'd0, 1'b0, 5);

        // Reset during ACCESS aborts the store.
        do_req(1'b1, 64'd7, 64'h1234, 1'b0, 0);
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd7; req_wdata = 64'hAA;
        tick();
        req_valid = 1'b0;
        chk("abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("abort_reset");
        tick();
        chk("abort_ready", 64'(req_ready), 64'd1);
        do_req(1'b0, 64'd7, 64'd0, 1'b0, 0);

        // Reset during RESP drops the response.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd5;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("resp_before_rst", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_outputs("resp_reset");

        // Reset and request together: reset wins.
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd5; req_wdata = 64'h55;
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        chk_reset_outputs("rst_vs_req");
        tick();
        chk("rst_vs_req_idle", 64'(busy), 64'd0);
        do_req(1'b0, 64'd5, 64'd0, 1'b0, 0);

        // Scrambled inputs after acceptance, every latency, plus random traffic.
        for (int s = 0; s < NI; s++) begin
            sel = s;
            #0;
            d = {$urandom, $urandom};
            do_req(1'b1, 64'd9, d, 1'b1, 0);
            do_req(1'b0, 64'd9, 64'd0, 1'b1, 1);
            for (int t = 0; t < 14; t++) begin
                if ($urandom_range(0, 7) == 0)
                    a = 64'd2048 + 64'($urandom_range(0, 100000));
                else
                    a = 64'($urandom_range(0, 7) * 256 + 3);
                w = 1'($urandom_range(0, 1));
                d = {$urandom, $urandom};
                do_req(w, a, d, 1'b1, $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
